// File: rtl/mf_disp_scan_timing.sv
// Raster scan timing generator with a windowed framebuffer read strobe and
// double-buffer swap control locked to the first vertical blanking line.
module mf_disp_scan_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_X0    = 192,
  parameter int FB_Y0    = 112,
  parameter int FB_W     = 256,
  parameter int FB_H     = 256,
  parameter int PIPE_DLY = 3
) (
  input  logic        pix_clk,
  input  logic        reset,
  input  logic        swap_req,
  output logic        pix_fb_active_sel,
  output logic        swap_done,
  output logic        pix_rd_vld,
  output logic [15:0] pix_rd_addr,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        in_window,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DLY     = 1 + PIPE_DLY;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] WX_BEG    = HW'(FB_X0);
  localparam logic [HW-1:0] WX_END    = HW'(FB_X0 + FB_W);
  localparam logic [VW-1:0] WY_BEG    = VW'(FB_Y0);
  localparam logic [VW-1:0] WY_END    = VW'(FB_Y0 + FB_H);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          raw_act, raw_win, raw_hs_n, raw_vs_n;
  logic          frame_origin, swap_point;

  logic [15:0]   next_idx_q, next_idx_d;
  logic [15:0]   pix_rd_addr_q, pix_rd_addr_d;
  logic          pix_rd_vld_q;
  logic          frame_start_q;
  logic          pending_q, pending_d;
  logic          sel_q, sel_d;
  logic          swap_done_q, swap_done_d;

  logic [DLY-1:0] de_pipe_q, de_pipe_d;
  logic [DLY-1:0] win_pipe_q, win_pipe_d;
  logic [DLY-1:0] hs_pipe_q, hs_pipe_d;
  logic [DLY-1:0] vs_pipe_q, vs_pipe_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  assign raw_act      = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
  assign raw_win      = (h_cnt_q >= WX_BEG) && (h_cnt_q < WX_END) &&
                        (v_cnt_q >= WY_BEG) && (v_cnt_q < WY_END);
  assign raw_hs_n     = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
  assign raw_vs_n     = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
  assign frame_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign swap_point   = (h_cnt_q == '0) && (v_cnt_q == V_ACT_END);

  // next_idx_q is the index of the next window pixel; the output register
  // latches it on each window cycle, so no multiplier is needed.
  always_comb begin
    next_idx_d    = frame_origin ? 16'd0 : next_idx_q;
    pix_rd_addr_d = frame_origin ? 16'd0 : pix_rd_addr_q;
    if (raw_win) begin
      pix_rd_addr_d = next_idx_d;
      next_idx_d    = next_idx_d + 16'd1;
    end
  end

  always_comb begin
    sel_d       = sel_q;
    swap_done_d = 1'b0;
    pending_d   = pending_q;
    if (swap_point && (pending_q || swap_req)) begin
      sel_d       = ~sel_q;
      swap_done_d = 1'b1;
      pending_d   = 1'b0;
    end else if (swap_req) begin
      pending_d = 1'b1;
    end
  end

  assign de_pipe_d[0]  = raw_act;
  assign win_pipe_d[0] = raw_win;
  assign hs_pipe_d[0]  = raw_hs_n;
  assign vs_pipe_d[0]  = raw_vs_n;

  generate
    for (genvar gi = 1; gi < DLY; gi++) begin : g_dly
      assign de_pipe_d[gi]  = de_pipe_q[gi-1];
      assign win_pipe_d[gi] = win_pipe_q[gi-1];
      assign hs_pipe_d[gi]  = hs_pipe_q[gi-1];
      assign vs_pipe_d[gi]  = vs_pipe_q[gi-1];
    end
  endgenerate

  always_ff @(posedge pix_clk) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      next_idx_q    <= '0;
      pix_rd_addr_q <= '0;
      pix_rd_vld_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pending_q     <= 1'b0;
      sel_q         <= 1'b0;
      swap_done_q   <= 1'b0;
      de_pipe_q     <= '0;
      win_pipe_q    <= '0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      next_idx_q    <= next_idx_d;
      pix_rd_addr_q <= pix_rd_addr_d;
      pix_rd_vld_q  <= raw_win;
      frame_start_q <= frame_origin;
      pending_q     <= pending_d;
      sel_q         <= sel_d;
      swap_done_q   <= swap_done_d;
      de_pipe_q     <= de_pipe_d;
      win_pipe_q    <= win_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
    end
  end

  assign pix_fb_active_sel = sel_q;
  assign swap_done         = swap_done_q;
  assign pix_rd_vld        = pix_rd_vld_q;
  assign pix_rd_addr       = pix_rd_addr_q;
  assign frame_start       = frame_start_q;
  assign de                = de_pipe_q[DLY-1];
  assign in_window         = win_pipe_q[DLY-1];
  assign hsync             = hs_pipe_q[DLY-1];
  assign vsync             = vs_pipe_q[DLY-1];

endmodule

// File: tb/tb_mf_disp_scan_timing.sv
// Bench for mf_disp_scan_timing on a shrunken raster: per-cycle scoreboard
// plus a table of per-frame swap scenarios and a mid-frame reset sequence.
module tb_mf_disp_scan_timing;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 12, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int X0 = 4, Y0 = 3, W = 8, H = 4;
  localparam int PDLY = 3;
  localparam int TDLY = 1 + PDLY;

  logic        pix_clk = 1'b0;
  logic        reset = 1'b1;
  logic        swap_req = 1'b0;
  logic        pix_fb_active_sel, swap_done, pix_rd_vld;
  logic [15:0] pix_rd_addr;
  logic        hsync, vsync, de, in_window, frame_start;

  always #5 pix_clk = ~pix_clk;

  mf_disp_scan_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FB_X0(X0), .FB_Y0(Y0), .FB_W(W), .FB_H(H),
    .PIPE_DLY(PDLY)
  ) dut (
    .pix_clk(pix_clk),
    .reset(reset),
    .swap_req(swap_req),
    .pix_fb_active_sel(pix_fb_active_sel),
    .swap_done(swap_done),
    .pix_rd_vld(pix_rd_vld),
    .pix_rd_addr(pix_rd_addr),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .in_window(in_window),
    .frame_start(frame_start)
  );

  typedef struct {
    logic        sel;
    logic        done;
    logic        vld;
    logic [15:0] addr;
    logic        fs;
    logic        de;
    logic        hs;
    logic        vs;
    logic        win;
  } exp_t;

  typedef struct {
    int   np;
    int   pv[3];
    int   ph[3];
    logic exp_sel;
    int   exp_done;
  } frame_vec_t;

  exp_t        q1[$];
  exp_t        q4[$];
  int          checks = 0;
  int          errors = 0;
  int          mpos = 0;
  logic        m_sel = 1'b0;
  logic        m_pend = 1'b0;
  logic [15:0] m_addr = 16'd0;
  frame_vec_t  fv[5];

  function automatic exp_t reset_rec();
    exp_t r;
    r.sel = 1'b0; r.done = 1'b0; r.vld = 1'b0; r.addr = 16'd0; r.fs = 1'b0;
    r.de = 1'b0; r.hs = 1'b1; r.vs = 1'b1; r.win = 1'b0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Compare against the scoreboard, push the expectation for the coming edge,
  // then advance one clock (returns just after the rising edge).
  task automatic step();
    exp_t e1, e4, r1, r4;
    int   h, v;
    logic win;
    @(negedge pix_clk);
    if (q1.size() > 0 && q4.size() > 0) begin
      e1 = q1.pop_front();
      e4 = q4.pop_front();
      checks++;
      if (pix_fb_active_sel !== e1.sel || swap_done !== e1.done || pix_rd_vld !== e1.vld ||
          pix_rd_addr !== e1.addr || frame_start !== e1.fs || de !== e4.de ||
          hsync !== e4.hs || vsync !== e4.vs || in_window !== e4.win) begin
        errors++;
        $display("FAIL scoreboard pos=%0d got sel=%b done=%b vld=%b addr=%0d fs=%b de=%b hs=%b vs=%b win=%b exp sel=%b done=%b vld=%b addr=%0d fs=%b de=%b hs=%b vs=%b win=%b",
                 mpos, pix_fb_active_sel, swap_done, pix_rd_vld, pix_rd_addr, frame_start,
                 de, hsync, vsync, in_window, e1.sel, e1.done, e1.vld, e1.addr, e1.fs,
                 e4.de, e4.hs, e4.vs, e4.win);
      end
    end
    if (reset) begin
      q1.delete();
      q4.delete();
      q1.push_back(reset_rec());
      for (int i = 0; i < TDLY; i++) q4.push_back(reset_rec());
      mpos = 0; m_sel = 1'b0; m_pend = 1'b0; m_addr = 16'd0;
    end else begin
      h = mpos % HT;
      v = mpos / HT;
      win = (h >= X0) && (h < X0 + W) && (v >= Y0) && (v < Y0 + H);
      r4 = reset_rec();
      r4.de  = (h < HA) && (v < VA);
      r4.win = win;
      r4.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
      r4.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
      q4.push_back(r4);
      r1 = reset_rec();
      r1.vld = win;
      if (mpos == 0) m_addr = 16'd0;
      if (win) m_addr = 16'((v - Y0) * W + (h - X0));
      r1.addr = m_addr;
      r1.fs = (mpos == 0);
      if (h == 0 && v == VA && (m_pend || swap_req)) begin
        m_sel = ~m_sel;
        r1.done = 1'b1;
        m_pend = 1'b0;
      end else if (swap_req) begin
        m_pend = 1'b1;
      end
      r1.sel = m_sel;
      q1.push_back(r1);
      mpos = (mpos + 1) % FRAME;
    end
    @(posedge pix_clk);
    #1;
  endtask

  task automatic goto_pos(input int target);
    int n = 0;
    while (mpos != target && n < 2 * FRAME) begin
      step();
      n++;
    end
    chk("goto_pos", mpos, target);
  endtask

  // Runs one full frame starting one cycle after frame_start.
  task automatic run_frame(input frame_vec_t f, input int idx);
    int          hs_lo = 0, vs_lo = 0, de_hi = 0, strobes = 0, fs_n = 0, done_n = 0;
    int          vld_rise = -1, win_rise = -1;
    logic [15:0] first_addr = 16'hffff;
    logic [15:0] last_addr = 16'd0;
    logic        pv_vld = 1'b0, pv_win = 1'b0;
    int          p;
    for (int i = 0; i < FRAME; i++) begin
      p = mpos;
      if (!hsync) hs_lo++;
      if (!vsync) vs_lo++;
      if (de) de_hi++;
      if (frame_start) fs_n++;
      if (swap_done) done_n++;
      if (pix_rd_vld) begin
        strobes++;
        last_addr = pix_rd_addr;
      end
      if (pix_rd_vld && !pv_vld && vld_rise < 0) begin
        vld_rise = p;
        first_addr = pix_rd_addr;
      end
      if (in_window && !pv_win && win_rise < 0) win_rise = p;
      pv_vld = pix_rd_vld;
      pv_win = in_window;
      swap_req = 1'b0;
      for (int k = 0; k < f.np; k++)
        if (p == f.pv[k] * HT + f.ph[k]) swap_req = 1'b1;
      step();
    end
    swap_req = 1'b0;
    $display("frame %0d sel=%b swaps=%0d strobes=%0d hs_lo=%0d vs_lo=%0d de=%0d",
             idx, pix_fb_active_sel, done_n, strobes, hs_lo, vs_lo, de_hi);
    chk("hsync_low", hs_lo, VT * HS);
    chk("vsync_low", vs_lo, VS * HT);
    chk("de_high", de_hi, HA * VA);
    chk("strobes", strobes, W * H);
    chk("frame_start_cnt", fs_n, 1);
    chk("swap_done_cnt", done_n, f.exp_done);
    chk("sel_after_frame", pix_fb_active_sel, f.exp_sel);
    chk("last_addr", last_addr, W * H - 1);
    chk("vld_rise_pos", vld_rise, Y0 * HT + X0 + 1);
    chk("first_addr", first_addr, 0);
    chk("win_align", win_rise - vld_rise, PDLY);
  endtask

  initial begin
    fv[0].np = 1; fv[0].pv = '{2, 0, 0};  fv[0].ph = '{5, 0, 0};  fv[0].exp_sel = 1'b1; fv[0].exp_done = 1;
    fv[1].np = 3; fv[1].pv = '{1, 3, 5};  fv[1].ph = '{7, 0, 20}; fv[1].exp_sel = 1'b0; fv[1].exp_done = 1;
    fv[2].np = 0; fv[2].pv = '{0, 0, 0};  fv[2].ph = '{0, 0, 0};  fv[2].exp_sel = 1'b0; fv[2].exp_done = 0;
    fv[3].np = 1; fv[3].pv = '{VA, 0, 0}; fv[3].ph = '{0, 0, 0};  fv[3].exp_sel = 1'b1; fv[3].exp_done = 1;
    fv[4].np = 0; fv[4].pv = '{0, 0, 0};  fv[4].ph = '{0, 0, 0};  fv[4].exp_sel = 1'b0; fv[4].exp_done = 0;

    reset = 1'b1;
    swap_req = 1'b0;
    step();
    step();
    chk("rst_sel", pix_fb_active_sel, 0);
    chk("rst_vld", pix_rd_vld, 0);
    chk("rst_addr", pix_rd_addr, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_de", de, 0);
    reset = 1'b0;
    step();
    chk("fs_after_release", frame_start, 1);
    goto_pos(1);

    for (int f = 0; f < 4; f++) run_frame(fv[f], f);

    // Mid-window reset with a swap pending and a coincident swap_req.
    goto_pos(27);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    goto_pos(4 * HT + 6);
    chk("pre_reset_vld", pix_rd_vld, 1);
    reset = 1'b1;
    swap_req = 1'b1;
    step();
    chk("mid_rst_sel", pix_fb_active_sel, 0);
    chk("mid_rst_done", swap_done, 0);
    chk("mid_rst_vld", pix_rd_vld, 0);
    chk("mid_rst_addr", pix_rd_addr, 0);
    chk("mid_rst_fs", frame_start, 0);
    chk("mid_rst_de", de, 0);
    chk("mid_rst_win", in_window, 0);
    chk("mid_rst_hsync", hsync, 1);
    chk("mid_rst_vsync", vsync, 1);
    reset = 1'b0;
    swap_req = 1'b0;
    step();
    chk("fs_after_mid_release", frame_start, 1);
    run_frame(fv[4], 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
